// File: rtl/seven_seg_scan_decoder.sv
// Scrapes a two-digit multiplexed seven-segment bus back into BCD digits and a binary value.
// Each phase is captured once after it has been stable for SETTLE synchronized cycles.
module seven_seg_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       ca,
    input  logic       cb,
    input  logic       cc,
    input  logic       cd,
    input  logic       ce,
    input  logic       cf,
    input  logic       cg,
    input  logic       AN0,
    input  logic       AN1,
    output logic [3:0] value,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       valid,
    output logic       err,
    output logic       stale
);

    localparam int unsigned SettleW  = $clog2(SETTLE + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
    localparam logic [SettleW-1:0]  SettleMax  = SettleW'(SETTLE);
    localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT);

    typedef enum logic [1:0] {StEmpty, StHaveOnes, StHaveTens, StCheck} state_e;

    // Returns {legal, digit} for a lit pattern ordered abcdefg.
    function automatic logic [4:0] seg_decode(input logic [6:0] lit);
        logic [4:0] r;
        case (lit)
            7'b1111110: r = {1'b1, 4'd0};
            7'b0110000: r = {1'b1, 4'd1};
            7'b1101101: r = {1'b1, 4'd2};
            7'b1111001: r = {1'b1, 4'd3};
            7'b0110011: r = {1'b1, 4'd4};
            7'b1011011: r = {1'b1, 4'd5};
            7'b1011111: r = {1'b1, 4'd6};
            7'b1110000: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1111011: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    logic [8:0]          pins;
    logic [8:0]          sync1_q, sync2_q;
    logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TimeoutW-1:0] stale_cnt_q, stale_cnt_d;
    logic                last_ph_q, last_vld_q;
    state_e              state_q;
    logic [3:0]          hold_ones_q, hold_tens_q;
    logic [3:0]          value_q, ones_q, tens_q;
    logic                valid_q, err_q, stale_q;

    logic                next_idle, capture;
    logic                cur_ones, cur_tens, cur_active, phase_flip, stale_reach;
    logic [4:0]          dec;
    logic [6:0]          sum;
    logic                frame_ok;

    assign pins = {AN1, AN0, ca, cb, cc, cd, ce, cf, cg};

    always_comb begin
        // Look one stage ahead so the counter restarts on the edge the synchronized vector moves.
        next_idle = (sync1_q[8] == sync1_q[7]);
        if (sync1_q != sync2_q || next_idle) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q == SettleMax) begin
            settle_cnt_d = SettleMax;
        end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end
        capture = (settle_cnt_d == SettleMax) && (settle_cnt_q != SettleMax);

        cur_ones   = (sync2_q[8:7] == 2'b10);
        cur_tens   = (sync2_q[8:7] == 2'b01);
        cur_active = cur_ones || cur_tens;
        phase_flip = cur_active && last_vld_q && (cur_tens != last_ph_q);
        if (phase_flip) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q == TimeoutMax) begin
            stale_cnt_d = TimeoutMax;
        end else begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end
        stale_reach = (stale_cnt_d == TimeoutMax) && (stale_cnt_q != TimeoutMax);

        dec      = seg_decode(~sync2_q[6:0]);
        sum      = 7'(hold_tens_q) * 7'd10 + 7'(hold_ones_q);
        frame_ok = (state_q == StCheck) && (sum <= 7'd15);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            settle_cnt_q <= '0;
            stale_cnt_q  <= '0;
            last_ph_q    <= 1'b0;
            last_vld_q   <= 1'b0;
        end else begin
            sync1_q      <= pins;
            sync2_q      <= sync1_q;
            settle_cnt_q <= settle_cnt_d;
            stale_cnt_q  <= stale_cnt_d;
            if (cur_active) begin
                last_ph_q  <= cur_tens;
                last_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StEmpty;
            hold_ones_q <= '0;
            hold_tens_q <= '0;
            value_q     <= '0;
            ones_q      <= '0;
            tens_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_q == StCheck) begin
                state_q <= StEmpty;
                if (frame_ok) begin
                    value_q <= sum[3:0];
                    ones_q  <= hold_ones_q;
                    tens_q  <= hold_tens_q;
                    valid_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (capture) begin
                if (!dec[4]) begin
                    err_q   <= 1'b1;
                    state_q <= StEmpty;
                end else if (cur_ones) begin
                    hold_ones_q <= dec[3:0];
                    state_q     <= (state_q == StHaveTens) ? StCheck : StHaveOnes;
                end else begin
                    hold_tens_q <= dec[3:0];
                    state_q     <= (state_q == StHaveOnes) ? StCheck : StHaveTens;
                end
            end
            if (frame_ok) begin
                stale_q <= 1'b0;
            end else if (stale_reach) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign value = value_q;
    assign ones  = ones_q;
    assign tens  = tens_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign stale = stale_q;

endmodule
